// File: rtl/ab_request_arbiter.sv
// Round-robin front end for associative_buffer: two requesters share the buffer,
// each accepted request becomes a one-cycle buffer command and a per-requester response.

`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 2
`endif
`ifndef REG_CTRL_NOP
`define REG_CTRL_NOP 2'b00
`endif
`ifndef REG_CTRL_LD
`define REG_CTRL_LD 2'b01
`endif
`ifndef REG_CTRL_INC
`define REG_CTRL_INC 2'b10
`endif
`ifndef REG_CTRL_CLR
`define REG_CTRL_CLR 2'b11
`endif

module ab_request_arbiter #(
    parameter int KEY_WIDTH      = 4,
    parameter int DATA_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_op0,
    input  logic [1:0]                 req_op1,
    input  logic [KEY_WIDTH-1:0]       req_key0,
    input  logic [KEY_WIDTH-1:0]       req_key1,
    input  logic [DATA_WIDTH-1:0]      req_data0,
    input  logic [DATA_WIDTH-1:0]      req_data1,
    output logic [1:0]                 req_ready,
    output logic [1:0]                 rsp_valid,
    output logic                       rsp_hit,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       busy,
    output logic [`REG_CTRL_WIDTH-1:0] buf_ctrl,
    output logic [KEY_WIDTH-1:0]       buf_key,
    output logic [DATA_WIDTH-1:0]      buf_data,
    output logic                       buf_trigger_read,
    input  logic [DATA_WIDTH-1:0]      buf_data_output,
    input  logic                       buf_data_valid
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_r;
    logic                  last_grant_r;
    logic [1:0]            op_r;
    logic                  id_r;
    logic [7:0]            cnt_r;
    logic                  grant_s;
    logic                  accept_s;
    logic [1:0]            sel_op_s;
    logic [KEY_WIDTH-1:0]  sel_key_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    // Buffer command for an operation; reads are signalled by trigger_read instead.
    function automatic logic [`REG_CTRL_WIDTH-1:0] ctrl_code(input logic [1:0] op);
        logic [`REG_CTRL_WIDTH-1:0] code;
        case (op)
            OP_LOAD:  code = `REG_CTRL_LD;
            OP_INC:   code = `REG_CTRL_INC;
            OP_CLEAR: code = `REG_CTRL_CLR;
            OP_READ:  code = `REG_CTRL_NOP;
            default:  code = `REG_CTRL_NOP;
        endcase
        return code;
    endfunction

    // Round-robin grant and combinational accept strobe, only offered in IDLE.
    always_comb begin
        grant_s   = 1'b0;
        req_ready = 2'b00;
        if (state_r == ST_IDLE) begin
            case (req_valid)
                2'b01:   grant_s = 1'b0;
                2'b10:   grant_s = 1'b1;
                2'b11:   grant_s = ~last_grant_r;
                default: grant_s = 1'b0;
            endcase
            if (req_valid != 2'b00) begin
                req_ready = grant_s ? 2'b10 : 2'b01;
            end else begin
                req_ready = 2'b00;
            end
        end else begin
            req_ready = 2'b00;
        end
    end

    // Fields of the granted requester.
    always_comb begin
        accept_s   = |(req_valid & req_ready);
        sel_op_s   = grant_s ? req_op1   : req_op0;
        sel_key_s  = grant_s ? req_key1  : req_key0;
        sel_data_s = grant_s ? req_data1 : req_data0;
    end

    // Sequencer: accept, issue one buffer pulse, optionally wait for read data, respond.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_r          <= ST_IDLE;
            last_grant_r     <= 1'b1;
            op_r             <= OP_LOAD;
            id_r             <= 1'b0;
            cnt_r            <= 8'd0;
            rsp_valid        <= 2'b00;
            rsp_hit          <= 1'b0;
            rsp_data         <= {DATA_WIDTH{1'b0}};
            busy             <= 1'b0;
            buf_ctrl         <= `REG_CTRL_NOP;
            buf_key          <= {KEY_WIDTH{1'b0}};
            buf_data         <= {DATA_WIDTH{1'b0}};
            buf_trigger_read <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r             <= sel_op_s;
                        id_r             <= grant_s;
                        last_grant_r     <= grant_s;
                        buf_key          <= sel_key_s;
                        buf_data         <= sel_data_s;
                        buf_ctrl         <= ctrl_code(sel_op_s);
                        buf_trigger_read <= (sel_op_s == OP_READ);
                        busy             <= 1'b1;
                        state_r          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    buf_ctrl         <= `REG_CTRL_NOP;
                    buf_trigger_read <= 1'b0;
                    cnt_r            <= 8'd0;
                    if (op_r == OP_READ) begin
                        state_r <= ST_WAIT_RD;
                    end else begin
                        rsp_valid <= id_r ? 2'b10 : 2'b01;
                        rsp_hit   <= 1'b1;
                        rsp_data  <= {DATA_WIDTH{1'b0}};
                        state_r   <= ST_RESP;
                    end
                end
                ST_WAIT_RD: begin
                    // Valid on the final counter cycle still counts as a hit.
                    if (buf_data_valid) begin
                        rsp_valid <= id_r ? 2'b10 : 2'b01;
                        rsp_hit   <= 1'b1;
                        rsp_data  <= buf_data_output;
                        state_r   <= ST_RESP;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        rsp_valid <= id_r ? 2'b10 : 2'b01;
                        rsp_hit   <= 1'b0;
                        rsp_data  <= {DATA_WIDTH{1'b0}};
                        state_r   <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 2'b00;
                    rsp_hit   <= 1'b0;
                    rsp_data  <= {DATA_WIDTH{1'b0}};
                    busy      <= 1'b0;
                    cnt_r     <= 8'd0;
                    buf_key   <= {KEY_WIDTH{1'b0}};
                    buf_data  <= {DATA_WIDTH{1'b0}};
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r          <= ST_IDLE;
                    rsp_valid        <= 2'b00;
                    busy             <= 1'b0;
                    buf_ctrl         <= `REG_CTRL_NOP;
                    buf_trigger_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ab_request_arbiter.sv
// Scoreboard bench for ab_request_arbiter: requester drivers push expected responses,
// a negedge monitor checks arbitration, buffer commands and responses.

`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 2
`endif
`ifndef REG_CTRL_NOP
`define REG_CTRL_NOP 2'b00
`endif
`ifndef REG_CTRL_LD
`define REG_CTRL_LD 2'b01
`endif
`ifndef REG_CTRL_INC
`define REG_CTRL_INC 2'b10
`endif
`ifndef REG_CTRL_CLR
`define REG_CTRL_CLR 2'b11
`endif

module tb_ab_request_arbiter;

    localparam int KW = 4;
    localparam int DW = 2;
    localparam int TO = 8;
    localparam int NEVER = 255;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef struct {
        logic          hit;
        logic [DW-1:0] data;
        int            lat;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic async_reset = 1'b1;
    logic req_v0 = 1'b0, req_v1 = 1'b0;
    logic [1:0] req_valid;
    logic [1:0] req_op0 = 2'b00, req_op1 = 2'b00;
    logic [KW-1:0] req_key0 = 4'h0, req_key1 = 4'h0;
    logic [DW-1:0] req_data0 = 2'b00, req_data1 = 2'b00;
    logic [1:0] req_ready, rsp_valid;
    logic rsp_hit, busy, buf_trigger_read;
    logic [DW-1:0] rsp_data, buf_data;
    logic [`REG_CTRL_WIDTH-1:0] buf_ctrl;
    logic [KW-1:0] buf_key;
    logic [DW-1:0] buf_data_output = 2'b00;
    logic buf_data_valid = 1'b0;

    assign req_valid = {req_v1, req_v0};

    exp_t q0[$];
    exp_t q1[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_k = NEVER;
    logic [DW-1:0] rd_v = 2'b00;

    ab_request_arbiter #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .async_reset(async_reset), .req_valid(req_valid),
        .req_op0(req_op0), .req_op1(req_op1), .req_key0(req_key0), .req_key1(req_key1),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data), .busy(busy),
        .buf_ctrl(buf_ctrl), .buf_key(buf_key), .buf_data(buf_data),
        .buf_trigger_read(buf_trigger_read), .buf_data_output(buf_data_output),
        .buf_data_valid(buf_data_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] ctrl_of(input logic [1:0] op);
        case (op)
            OP_LOAD: return `REG_CTRL_LD;
            OP_INC:  return `REG_CTRL_INC;
            OP_CLR:  return `REG_CTRL_CLR;
            default: return `REG_CTRL_NOP;
        endcase
    endfunction

    // Reference: reads hit if data shows up within TO cycles of entering the wait; k counts from T+2.
    function automatic exp_t model(input logic [1:0] op, input int k, input logic [DW-1:0] v, input int acc);
        exp_t e;
        e.acc = acc;
        if (op != OP_READ) begin
            e.hit = 1'b1; e.data = '0; e.lat = 2;
        end else if (k < TO) begin
            e.hit = 1'b1; e.data = v; e.lat = 3 + k;
        end else begin
            e.hit = 1'b0; e.data = '0; e.lat = TO + 2;
        end
        return e;
    endfunction

    task automatic drive(input int id, input logic v, input logic [1:0] op,
                         input logic [KW-1:0] key, input logic [DW-1:0] data);
        if (id == 0) begin
            req_v0 = v; req_op0 = op; req_key0 = key; req_data0 = data;
        end else begin
            req_v1 = v; req_op1 = op; req_key1 = key; req_data1 = data;
        end
    endtask

    // Present one request, hold it until accepted, push the expected response.
    task automatic do_req(input int id, input logic [1:0] op, input logic [KW-1:0] key,
                          input logic [DW-1:0] data, input int k, input logic [DW-1:0] rv);
        bit got = 1'b0;
        exp_t e;
        drive(id, 1'b1, op, key, data);
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: requester %0d never saw ready", id);
        end else begin
            if (op == OP_READ) begin
                rd_k = k; rd_v = rv;
            end
            e = model(op, k, rv, cyc);
            if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk); #1;
        drive(id, 1'b0, 2'($urandom), 4'($urandom), 2'($urandom));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain: pending responses q0=%0d q1=%0d busy=%0b", q0.size(), q1.size(), busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_driver(input int id, input int n);
        logic [1:0] op;
        int k;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            op = 2'($urandom);
            k = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, TO);
            do_req(id, op, 4'($urandom), 2'($urandom), k, 2'($urandom));
        end
    endtask

    // Buffer emulator: after a trigger, pulse data_valid at T+2+k (never for k = NEVER).
    initial begin
        int k;
        logic [DW-1:0] v;
        forever begin
            @(negedge clk);
            if (buf_trigger_read === 1'b1 && !async_reset) begin
                k = rd_k; v = rd_v;
                if (k != NEVER) begin
                    repeat (k + 1) @(posedge clk);
                    #1;
                    buf_data_valid = 1'b1; buf_data_output = v;
                    @(posedge clk); #1;
                    buf_data_valid = 1'b0; buf_data_output = 2'($urandom);
                end
            end
        end
    end

    // Monitor: arbitration model, buffer command check, response scoreboard.
    initial begin
        logic last_g = 1'b1;
        logic g;
        bit iss_pend = 1'b0;
        logic [1:0] iss_op = 2'b00;
        logic [KW-1:0] iss_key = 4'h0;
        logic [DW-1:0] iss_data = 2'b00;
        exp_t e;
        forever begin
            @(negedge clk);
            if (async_reset) begin
                last_g = 1'b1; iss_pend = 1'b0;
                continue;
            end
            if (iss_pend) begin
                chk("issue_ctrl", 32'(buf_ctrl), 32'(ctrl_of(iss_op)));
                chk("issue_trigger", 32'(buf_trigger_read), 32'(iss_op == OP_READ));
                chk("issue_key", 32'(buf_key), 32'(iss_key));
                chk("issue_data", 32'(buf_data), 32'(iss_data));
                iss_pend = 1'b0;
            end else begin
                chk("quiet_ctrl", 32'(buf_ctrl), 32'(`REG_CTRL_NOP));
                chk("quiet_trigger", 32'(buf_trigger_read), 32'd0);
            end
            if (!busy && req_valid != 2'b00) begin
                g = (req_valid == 2'b01) ? 1'b0 : (req_valid == 2'b10) ? 1'b1 : ~last_g;
                chk("grant", 32'(req_ready), g ? 32'd2 : 32'd1);
                last_g = g;
                iss_pend = 1'b1;
                iss_op   = g ? req_op1 : req_op0;
                iss_key  = g ? req_key1 : req_key0;
                iss_data = g ? req_data1 : req_data0;
            end else begin
                chk("ready_low", 32'(req_ready), 32'd0);
            end
            if (rsp_valid == 2'b01 || rsp_valid == 2'b10) begin
                if ((rsp_valid == 2'b01 && q0.size() == 0) || (rsp_valid == 2'b10 && q1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b with no pending request", rsp_valid);
                end else begin
                    e = (rsp_valid == 2'b01) ? q0.pop_front() : q1.pop_front();
                    chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end else if (rsp_valid != 2'b00) begin
                checks++; errors++;
                $display("FAIL rsp_onehot: rsp_valid=%b", rsp_valid);
            end else begin
                chk("rsp_quiet", 32'({rsp_hit, rsp_data}), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_ctrl", 32'(buf_ctrl), 32'(`REG_CTRL_NOP));
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_bufs", 32'({buf_key, buf_data, buf_trigger_read, rsp_hit, rsp_data}), 32'd0);
        @(posedge clk); #1;
        async_reset = 1'b0;
        @(posedge clk); #1;

        do_req(0, OP_LOAD, 4'h5, 2'b10, NEVER, 2'b00);
        wait_idle();
        do_req(0, OP_READ, 4'h5, 2'b00, 2, 2'b10);
        wait_idle();
        do_req(1, OP_READ, 4'h9, 2'b00, TO - 1, 2'b01);
        wait_idle();
        do_req(1, OP_READ, 4'h9, 2'b00, TO, 2'b11);
        wait_idle();
        do_req(1, OP_INC, 4'h3, 2'b00, NEVER, 2'b00);
        wait_idle();
        do_req(1, OP_CLR, 4'h3, 2'b00, NEVER, 2'b00);
        wait_idle();

        // Timeout read: busy from T+1 through T+10.
        do_req(0, OP_READ, 4'hA, 2'b00, NEVER, 2'b00);
        for (int i = 1; i <= TO + 2; i++) begin
            @(negedge clk);
            chk("busy_during_read", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("busy_after_read", 32'(busy), 32'd0);
        wait_idle();

        // Reset during WAIT_RD aborts silently.
        do_req(0, OP_READ, 4'h7, 2'b00, NEVER, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        async_reset = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_ctrl", 32'(buf_ctrl), 32'(`REG_CTRL_NOP));
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bufs", 32'({buf_key, buf_data, buf_trigger_read, rsp_hit, rsp_data}), 32'd0);
        q0.delete(); q1.delete();
        @(posedge clk); #1;
        async_reset = 1'b0;
        fork
            do_req(0, OP_LOAD, 4'h1, 2'b01, NEVER, 2'b00);
            do_req(1, OP_LOAD, 4'h2, 2'b10, NEVER, 2'b00);
        join
        wait_idle();

        // Back-to-back contention: grants must alternate.
        fork
            for (int i = 0; i < 2; i++) do_req(0, OP_LOAD, 4'(i), 2'b01, NEVER, 2'b00);
            for (int i = 0; i < 2; i++) do_req(1, OP_LOAD, 4'(i + 8), 2'b11, NEVER, 2'b00);
        join
        wait_idle();

        fork
            rand_driver(0, 25);
            rand_driver(1, 25);
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
